// File: rtl/sic1_sequencer_pkg.sv
// Shared definitions for the SIC-1 SUBLEQ fetch/execute sequencer.
package sic1_sequencer_pkg;

    localparam logic [7:0] ADDR_MAX_DEF = 8'd252;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_LOADB  = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALT   = 3'd5,
        ST_LD_RD  = 3'd6,
        ST_LD_WR  = 3'd7
    } state_t;

    // Loader may only borrow the write port while the core is stopped
    function automatic logic is_stopped(input state_t s);
        return (s == ST_IDLE) || (s == ST_HALT);
    endfunction

endpackage

// File: rtl/sic1_subleq_alu.sv
// SUBLEQ datapath: difference, branch decision, next PC and halt detection.
module sic1_subleq_alu #(
    parameter logic [7:0] ADDR_MAX = 8'd252
) (
    input  logic [7:0] va,
    input  logic [7:0] vb,
    input  logic [7:0] c,
    input  logic [7:0] pc,
    output logic [7:0] r_c,
    output logic [7:0] npc_c,
    output logic       halt_c
);

    logic branch;

    // Branch when the 8-bit two's-complement result is negative or zero
    always_comb begin
        r_c    = va - vb;
        branch = r_c[7] | (r_c == 8'd0);
        npc_c  = branch ? c : pc + 8'd3;
        halt_c = npc_c > ADDR_MAX;
    end

endmodule

// File: rtl/sic1_sequencer.sv
// SIC-1 fetch/execute controller; shares the memory write port with a byte loader.
module sic1_sequencer
    import sic1_sequencer_pkg::*;
#(
    parameter logic [7:0]  ADDR_MAX = ADDR_MAX_DEF,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             halted,
    output logic             busy,
    output logic [7:0]       pc,
    output logic [CNT_W-1:0] icount,
    input  logic             prog_valid,
    output logic             prog_ready,
    input  logic [7:0]       prog_addr,
    input  logic [7:0]       prog_data,
    output logic             mem_wr_en,
    output logic [7:0]       mem_wr_addr,
    output logic [7:0]       mem_wr_byte,
    output logic [5:0]       mem_ra_addr,
    output logic [5:0]       mem_rb_addr,
    output logic [1:0]       mem_pc_low,
    input  logic [7:0]       mem_a,
    input  logic [7:0]       mem_b,
    input  logic [7:0]       mem_c,
    output logic [1:0]       mem_rb_idx,
    input  logic [7:0]       mem_rb_byte
);

    state_t     state_q;
    state_t     state_d;
    state_t     ret_q;
    logic [7:0] fa_q;
    logic [7:0] fc_q;
    logic [7:0] vb_q;
    logic [7:0] ld_addr_q;
    logic [7:0] ld_data_q;
    logic [7:0] alu_r;
    logic [7:0] alu_npc;
    logic       alu_halt;

    sic1_subleq_alu #(
        .ADDR_MAX (ADDR_MAX)
    ) u_alu (
        .va     (mem_rb_byte),
        .vb     (vb_q),
        .c      (fc_q),
        .pc     (pc),
        .r_c    (alu_r),
        .npc_c  (alu_npc),
        .halt_c (alu_halt)
    );

    assign halted     = (state_q == ST_HALT);
    assign prog_ready = is_stopped(state_q);
    assign busy       = ~is_stopped(state_q);

    // Next-state logic; a loader request in IDLE/HALT takes priority over start
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (prog_valid)  state_d = ST_LD_RD;
                else if (start)  state_d = ST_FETCH;
            end
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = ST_LOADB;
            ST_LOADB:  state_d = ST_EXEC;
            ST_EXEC:   state_d = alu_halt ? ST_HALT : ST_FETCH;
            ST_LD_RD:  state_d = ST_LD_WR;
            ST_LD_WR:  state_d = ret_q;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Memory port drive; a write is suppressed while rst is asserted so an abort never writes
    always_comb begin
        mem_wr_en   = 1'b0;
        mem_wr_addr = 8'd0;
        mem_wr_byte = 8'd0;
        mem_ra_addr = 6'd0;
        mem_rb_addr = 6'd0;
        mem_pc_low  = 2'd0;
        mem_rb_idx  = 2'd0;
        case (state_q)
            ST_FETCH: begin
                mem_ra_addr = pc[7:2];
                mem_rb_addr = pc[7:2] + 6'd1;
                mem_pc_low  = pc[1:0];
            end
            ST_DECODE: begin
                mem_rb_addr = mem_b[7:2];
                mem_rb_idx  = mem_b[1:0];
            end
            ST_LOADB: begin
                mem_ra_addr = fa_q[7:2];
                mem_rb_addr = fa_q[7:2];
                mem_rb_idx  = fa_q[1:0];
            end
            ST_EXEC: begin
                mem_ra_addr = fa_q[7:2];
                mem_rb_addr = fa_q[7:2];
                mem_rb_idx  = fa_q[1:0];
                mem_wr_en   = ~rst;
                mem_wr_addr = fa_q;
                mem_wr_byte = alu_r;
            end
            ST_LD_RD: begin
                mem_ra_addr = ld_addr_q[7:2];
            end
            ST_LD_WR: begin
                mem_ra_addr = ld_addr_q[7:2];
                mem_wr_en   = ~rst;
                mem_wr_addr = ld_addr_q;
                mem_wr_byte = ld_data_q;
            end
            default: ;
        endcase
    end

    // State register plus instruction, operand, PC, counter and loader registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ret_q     <= ST_IDLE;
            pc        <= 8'd0;
            icount    <= '0;
            fa_q      <= 8'd0;
            fc_q      <= 8'd0;
            vb_q      <= 8'd0;
            ld_addr_q <= 8'd0;
            ld_data_q <= 8'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE, ST_HALT: begin
                    if (prog_valid) begin
                        ld_addr_q <= prog_addr;
                        ld_data_q <= prog_data;
                        ret_q     <= state_q;
                    end else if (start) begin
                        pc     <= 8'd0;
                        icount <= '0;
                    end
                end
                ST_DECODE: begin
                    fa_q <= mem_a;
                    fc_q <= mem_c;
                end
                ST_LOADB: begin
                    vb_q <= mem_rb_byte;
                end
                ST_EXEC: begin
                    pc <= alu_npc;
                    if (icount != '1) icount <= icount + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sic1_sequencer.sv
// Directed bench for sic1_sequencer with a behavioural memory block and an ISA-level scoreboard.
module tb_sic1_sequencer;

    localparam int unsigned CW      = 7;
    localparam int          CNT_MAX = (1 << CW) - 1;
    localparam logic [7:0]  UI_VAL  = 8'h5A;

    logic          clk = 1'b0;
    logic          rst, start, halted, busy;
    logic [7:0]    pc;
    logic [CW-1:0] icount;
    logic          prog_valid, prog_ready;
    logic [7:0]    prog_addr, prog_data;
    logic          mem_wr_en;
    logic [7:0]    mem_wr_addr, mem_wr_byte;
    logic [5:0]    mem_ra_addr, mem_rb_addr;
    logic [1:0]    mem_pc_low, mem_rb_idx;
    logic [7:0]    mem_a, mem_b, mem_c, mem_rb_byte;

    logic [7:0]    ram [256];
    logic [7:0]    ref_mem [256];
    logic          mem_clr;
    logic [7:0]    ui_in, uo_out;
    logic          out_strobe;

    logic [15:0]   exp_q [$];
    int            wr_cyc [$];
    int            cyc, strobes, checks, errors, n_run;
    logic [5:0]    last_ra;

    always #5 clk = ~clk;

    sic1_sequencer #(.ADDR_MAX(8'd252), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .halted(halted), .busy(busy),
        .pc(pc), .icount(icount), .prog_valid(prog_valid), .prog_ready(prog_ready),
        .prog_addr(prog_addr), .prog_data(prog_data), .mem_wr_en(mem_wr_en),
        .mem_wr_addr(mem_wr_addr), .mem_wr_byte(mem_wr_byte),
        .mem_ra_addr(mem_ra_addr), .mem_rb_addr(mem_rb_addr), .mem_pc_low(mem_pc_low),
        .mem_a(mem_a), .mem_b(mem_b), .mem_c(mem_c), .mem_rb_idx(mem_rb_idx),
        .mem_rb_byte(mem_rb_byte)
    );

    // Instruction field k taken from the 8-byte window formed by words ra (low) and rb (high)
    function automatic logic [7:0] fld(input logic [5:0] wa, input logic [5:0] wb,
                                       input logic [1:0] lo, input logic [2:0] k);
        logic [2:0] i;
        i = {1'b0, lo} + k;
        return i[2] ? ram[{wb, i[1:0]}] : ram[{wa, i[1:0]}];
    endfunction

    // Memory block: registered reads, input port at 253, output register with strobe at 254
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
            uo_out     <= 8'h00;
            out_strobe <= 1'b0;
        end else begin
            mem_a       <= fld(mem_ra_addr, mem_rb_addr, mem_pc_low, 3'd0);
            mem_b       <= fld(mem_ra_addr, mem_rb_addr, mem_pc_low, 3'd1);
            mem_c       <= fld(mem_ra_addr, mem_rb_addr, mem_pc_low, 3'd2);
            mem_rb_byte <= ({mem_rb_addr, mem_rb_idx} == 8'd253) ? ui_in
                                                                 : ram[{mem_rb_addr, mem_rb_idx}];
            out_strobe  <= 1'b0;
            if (mem_wr_en) begin
                ram[mem_wr_addr] <= mem_wr_byte;
                if (mem_wr_addr == 8'd254) begin
                    uo_out     <= mem_wr_byte;
                    out_strobe <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick_raw();
        @(posedge clk);
        #1;
        cyc++;
        if (out_strobe === 1'b1) strobes++;
    endtask

    // Advance one cycle and score any memory write issued in the new cycle
    task automatic tick();
        logic [15:0] e;
        tick_raw();
        if (mem_wr_en === 1'b1) begin
            chk("rmw_word", 32'(mem_wr_addr[7:2]), 32'(last_ra));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_write: observed %0h:%0h expected none",
                       mem_wr_addr, mem_wr_byte);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_wr_addr), 32'(e[15:8]));
                chk("wr_byte", 32'(mem_wr_byte), 32'(e[7:0]));
            end
            wr_cyc.push_back(cyc);
        end
        last_ra = mem_ra_addr;
    endtask

    task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
        prog_valid = 1'b1;
        prog_addr  = a;
        prog_data  = d;
        exp_q.push_back({a, d});
        ref_mem[a] = d;
        tick();
        prog_valid = 1'b0;
        chk("ld_ready_low", 32'(prog_ready), 32'd0);
        tick();
        tick();
        chk("ld_ready_back", 32'(prog_ready), 32'd1);
    endtask

    // ISA-level reference: executes up to cap instructions on ref_mem, queuing expected writes
    task automatic ref_run(input int cap, output int n, output logic [7:0] fpc, output logic hlt);
        logic [7:0] p, a, b, c, va, vb, r;
        p = 8'd0; n = 0; hlt = 1'b0;
        while (n < cap && !hlt) begin
            a  = ref_mem[p];
            b  = ref_mem[8'(p + 8'd1)];
            c  = ref_mem[8'(p + 8'd2)];
            va = (a == 8'd253) ? UI_VAL : ref_mem[a];
            vb = (b == 8'd253) ? UI_VAL : ref_mem[b];
            r  = va - vb;
            exp_q.push_back({a, r});
            ref_mem[a] = r;
            p = (r[7] || r == 8'd0) ? c : 8'(p + 8'd3);
            n++;
            if (p > 8'd252) hlt = 1'b1;
        end
        fpc = p;
    endtask

    task automatic run_prog(input int cap, output int n);
        logic [7:0] fpc;
        logic       hlt;
        int         s;
        ref_run(cap, n, fpc, hlt);
        wr_cyc.delete();
        strobes = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        s = cyc;
        chk("start_icount_clr", 32'(icount), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
        repeat (4 * n) tick();
        chk("run_pc", 32'(pc), 32'(fpc));
        chk("run_icount", 32'(icount), 32'((n > CNT_MAX) ? CNT_MAX : n));
        chk("run_halted", 32'(halted), 32'(hlt));
        chk("run_nwrites", 32'(wr_cyc.size()), 32'(n));
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        if (wr_cyc.size() > 0) chk("first_wr_latency", 32'(wr_cyc[0] - s), 32'd3);
        for (int i = 1; i < wr_cyc.size(); i++)
            chk("wr_spacing", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd4);
        if (!hlt) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; strobes = 0; last_ra = 6'd0;
        rst = 1'b1; start = 1'b0; prog_valid = 1'b0; prog_addr = 8'd0; prog_data = 8'd0;
        ui_in = UI_VAL; mem_clr = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        tick();
        tick();
        mem_clr = 1'b0;
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_icount", 32'(icount), 32'd0);
        chk("rst_ready", 32'(prog_ready), 32'd1);
        chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_addrs", 32'({mem_wr_addr, mem_wr_byte, mem_ra_addr, mem_rb_addr,
                              mem_pc_low, mem_rb_idx}), 32'd0);

        // Branching instruction to 255 halts
        load_byte(8'd0, 8'd3); load_byte(8'd1, 8'd4); load_byte(8'd2, 8'd255);
        load_byte(8'd3, 8'd5); load_byte(8'd4, 8'd7);
        run_prog(16, n_run);
        chk("t1_pc", 32'(pc), 32'd255);
        chk("t1_mem3", 32'(ram[3]), 32'hFE);

        // Loader used from HALT returns to HALT
        load_byte(8'd3, 8'd9);
        chk("ld_ret_halt", 32'(halted), 32'd1);

        // Non-branching instruction falls through to pc+3
        run_prog(1, n_run);
        chk("t2_mem3", 32'(ram[3]), 32'h02);
        load_byte(8'd3, 8'd9);
        run_prog(16, n_run);

        // Reset asserted during EXEC aborts without a write
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick_raw();
        chk("exec_reached", 32'(mem_wr_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_exec_no_wr", 32'(mem_wr_en), 32'd0);
        tick_raw();
        rst = 1'b0;
        last_ra = mem_ra_addr;
        chk("rst_exec_busy", 32'(busy), 32'd0);
        chk("rst_exec_halted", 32'(halted), 32'd0);
        chk("rst_exec_pc", 32'(pc), 32'd0);
        chk("rst_exec_mem", 32'(ram[3]), 32'(ref_mem[3]));
        tick();

        // Write to the output port at 254
        load_byte(8'd0, 8'd254); load_byte(8'd1, 8'd20); load_byte(8'd2, 8'd255);
        load_byte(8'd20, 8'hFF); load_byte(8'd254, 8'h7F);
        run_prog(16, n_run);
        chk("t4_uo_out", 32'(uo_out), 32'h80);
        chk("t4_strobe_cycles", 32'(strobes), 32'd1);

        // Load and start in the same cycle: load wins, core stays idle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        prog_valid = 1'b1; prog_addr = 8'd40; prog_data = 8'h33; start = 1'b1;
        exp_q.push_back({8'd40, 8'h33});
        ref_mem[40] = 8'h33;
        tick();
        prog_valid = 1'b0; start = 1'b0;
        chk("ls_busy_ld", 32'(busy), 32'd1);
        chk("ls_ready_ld", 32'(prog_ready), 32'd0);
        tick();
        tick();
        chk("ls_idle_busy", 32'(busy), 32'd0);
        chk("ls_idle_halted", 32'(halted), 32'd0);
        repeat (6) tick();
        chk("ls_no_run", 32'(busy), 32'd0);
        chk("ls_mem", 32'(ram[40]), 32'h33);
        chk("ls_sb_drain", 32'(exp_q.size()), 32'd0);

        // Long loop saturates icount; restart clears it
        load_byte(8'd0, 8'd16); load_byte(8'd1, 8'd17); load_byte(8'd2, 8'd0);
        load_byte(8'd3, 8'd18); load_byte(8'd4, 8'd18); load_byte(8'd5, 8'd255);
        load_byte(8'd16, 8'h80); load_byte(8'd17, 8'hFF); load_byte(8'd18, 8'h00);
        run_prog(400, n_run);
        chk("sat_icount", 32'(icount), 32'(CNT_MAX));
        run_prog(400, n_run);
        chk("restart_icount", 32'(icount), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
